// File: rtl/jpeg_mcu_sequencer.sv
// Per-MCU stage sequencer for the JPEG encoder: load -> DCT -> capture -> quantize/zigzag -> Huffman,
// once per component, with per-component DC prediction and a restart-interval MCU counter.
module jpeg_mcu_sequencer #(
    parameter int NUM_COMP = 3,
    parameter int BLK_PIX  = 64,
    parameter int ROWS     = 8,
    parameter int DCT_LAT  = 4,
    parameter int DC_W     = 12,
    parameter int RST_INTV = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mcu_start,
    input  logic                   abort,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic                   input_1pix_enable,
    output logic                   dct_enable,
    output logic                   dct_input_enable,
    output logic [7:0]             matrix_row,
    output logic                   zigzag_input_enable,
    output logic                   Huffman_start,
    input  logic                   huff_done,
    output logic                   is_luminance,
    output logic [1:0]             comp_idx,
    input  logic                   dc_valid,
    input  logic signed [DC_W-1:0] dc_coef,
    output logic                   dc_diff_valid,
    output logic signed [DC_W:0]   dc_diff,
    output logic                   rst_marker,
    output logic                   mcu_done,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DCT,
        S_CAPT,
        S_QUANT,
        S_HUFF
    } state_t;

    localparam int CNT_W = $clog2(BLK_PIX + DCT_LAT + 1);

    localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(BLK_PIX - 1);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(DCT_LAT - 1);
    localparam logic [7:0]       ROW_LAST  = 8'(ROWS - 1);
    localparam logic [1:0]       COMP_LAST = 2'(NUM_COMP - 1);
    localparam logic [15:0]      INTV_LAST = 16'(RST_INTV - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic                   huff_first;
    logic [15:0]            mcu_cnt;
    logic signed [DC_W-1:0] pred [4];
    logic signed [DC_W-1:0] pred_sel;

    always_ff @(posedge clock) begin
        if (reset || abort) state <= S_IDLE;
        else                state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt           = state;
        pix_ready           = 1'b0;
        dct_enable          = 1'b0;
        dct_input_enable    = 1'b0;
        zigzag_input_enable = 1'b0;
        Huffman_start       = 1'b0;
        mcu_done            = 1'b0;
        rst_marker          = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (mcu_start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid && cnt == PIX_LAST) state_nxt = S_DCT;
            end
            S_DCT: begin
                dct_enable = (cnt == '0);
                if (cnt == LAT_LAST) state_nxt = S_CAPT;
            end
            S_CAPT: begin
                dct_input_enable = 1'b1;
                state_nxt        = S_QUANT;
            end
            S_QUANT: begin
                zigzag_input_enable = 1'b1;
                if (matrix_row == ROW_LAST) state_nxt = S_HUFF;
            end
            S_HUFF: begin
                Huffman_start = huff_first;
                // huff_done on the start cycle belongs to the previous block and is ignored
                if (!huff_first && huff_done) begin
                    if (comp_idx == COMP_LAST) begin
                        state_nxt  = S_IDLE;
                        mcu_done   = 1'b1;
                        rst_marker = (RST_INTV > 0) && (mcu_cnt == INTV_LAST);
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt  = S_IDLE;
            mcu_done   = 1'b0;
            rst_marker = 1'b0;
        end
    end

    assign input_1pix_enable = pix_valid & pix_ready;
    assign busy              = (state != S_IDLE);
    assign is_luminance      = (comp_idx == 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            cnt        <= '0;
            matrix_row <= '0;
            comp_idx   <= '0;
            huff_first <= 1'b0;
            mcu_cnt    <= '0;
        end else begin
            if (state != state_nxt)
                cnt <= '0;
            else if ((state == S_LOAD && pix_valid) || state == S_DCT)
                cnt <= cnt + CNT_W'(1);

            if (state == S_QUANT && state_nxt == S_QUANT) matrix_row <= matrix_row + 8'd1;
            else                                          matrix_row <= '0;

            huff_first <= (state_nxt == S_HUFF) && (state != S_HUFF);

            if (state == S_IDLE && mcu_start)             comp_idx <= '0;
            else if (state == S_HUFF && state_nxt == S_LOAD) comp_idx <= comp_idx + 2'd1;
            else if (mcu_done)                            comp_idx <= '0;

            if (rst_marker)                     mcu_cnt <= '0;
            else if (mcu_done && RST_INTV > 0)  mcu_cnt <= mcu_cnt + 16'd1;
        end
    end

    // a restart clears the predictors on the same edge, so a coincident DC sees zero
    assign pred_sel = rst_marker ? '0 : pred[comp_idx];

    // NOTE: the predictor array is explicitly reset because stale predictors would corrupt the first DC diffs of a new image.
    always_ff @(posedge clock) begin
        if (reset || abort) begin
            for (int i = 0; i < 4; i++) pred[i] <= '0;
            dc_diff_valid <= 1'b0;
            dc_diff       <= '0;
        end else begin
            dc_diff_valid <= dc_valid;
            if (rst_marker)
                for (int i = 0; i < 4; i++) pred[i] <= '0;
            if (dc_valid) begin
                dc_diff        <= {dc_coef[DC_W-1], dc_coef} - {pred_sel[DC_W-1], pred_sel};
                pred[comp_idx] <= dc_coef;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_mcu_sequencer.sv
// Randomized and directed bench for jpeg_mcu_sequencer; a cycle-by-cycle expectation per MCU phase
// plus an integer DC-predictor model.
module tb_jpeg_mcu_sequencer;

    localparam int NUM_COMP = 3;
    localparam int BLK_PIX  = 64;
    localparam int ROWS     = 8;
    localparam int DCT_LAT  = 4;
    localparam int DC_W     = 12;
    localparam int RST_INTV = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 mcu_start = 1'b0;
    logic                 abort = 1'b0;
    logic                 pix_valid = 1'b0;
    logic                 pix_ready;
    logic                 input_1pix_enable;
    logic                 dct_enable;
    logic                 dct_input_enable;
    logic [7:0]           matrix_row;
    logic                 zigzag_input_enable;
    logic                 Huffman_start;
    logic                 huff_done = 1'b0;
    logic                 is_luminance;
    logic [1:0]           comp_idx;
    logic                 dc_valid = 1'b0;
    logic [DC_W-1:0]      dc_coef = '0;
    logic                 dc_diff_valid;
    logic [DC_W:0]        dc_diff;
    logic                 rst_marker;
    logic                 mcu_done;
    logic                 busy;

    jpeg_mcu_sequencer #(
        .NUM_COMP(NUM_COMP), .BLK_PIX(BLK_PIX), .ROWS(ROWS),
        .DCT_LAT(DCT_LAT), .DC_W(DC_W), .RST_INTV(RST_INTV)
    ) dut (
        .clock(clock), .reset(reset), .mcu_start(mcu_start), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .input_1pix_enable(input_1pix_enable),
        .dct_enable(dct_enable), .dct_input_enable(dct_input_enable), .matrix_row(matrix_row),
        .zigzag_input_enable(zigzag_input_enable), .Huffman_start(Huffman_start),
        .huff_done(huff_done), .is_luminance(is_luminance), .comp_idx(comp_idx),
        .dc_valid(dc_valid), .dc_coef(dc_coef), .dc_diff_valid(dc_diff_valid),
        .dc_diff(dc_diff), .rst_marker(rst_marker), .mcu_done(mcu_done), .busy(busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // reference model state
    int   pred [4];
    logic dcv_exp;
    int   dcd_exp;
    int   done_cnt;
    int   idle_comp;
    logic rand_dc;
    int   last_dc;
    int   c0_diff;
    int   obs_in1;
    int   obs_rst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // {busy, pix_ready, input_1pix_enable, dct_enable, dct_input_enable, zigzag, Huffman_start, mcu_done, rst_marker}
    function automatic logic [8:0] stb(input logic b, pr, in1, de, die, zz, hs, md, rm);
        return {b, pr, in1, de, die, zz, hs, md, rm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) pred[i] = 0;
        dcv_exp   = 1'b0;
        dcd_exp   = 0;
        done_cnt  = 0;
        idle_comp = 0;
    endtask

    task automatic step(input logic ms, input logic pv, input logic hd, input logic dv_in,
                        input int coef_in, input logic ab, input logic [8:0] es,
                        input int erow, input int ecomp, input string tag);
        logic       dv;
        int         coef;
        logic [8:0] obs;
        dv   = dv_in;
        coef = coef_in;
        if (rand_dc && !dv && $urandom_range(0, 7) == 0) begin
            dv   = 1'b1;
            coef = int'($urandom_range(0, 4095)) - 2048;
        end
        if (ab || ecomp < 0) dv = 1'b0;
        @(posedge clock);
        #2;
        mcu_start = ms;
        pix_valid = pv;
        huff_done = hd;
        dc_valid  = dv;
        dc_coef   = coef[DC_W-1:0];
        abort     = ab;
        @(negedge clock);
        obs = {busy, pix_ready, input_1pix_enable, dct_enable, dct_input_enable,
               zigzag_input_enable, Huffman_start, mcu_done, rst_marker};
        check({tag, " strobes"}, 32'(obs), 32'(es));
        check({tag, " row"}, 32'(matrix_row), 32'(erow));
        if (ecomp >= 0) begin
            check({tag, " comp"}, 32'(comp_idx), 32'(ecomp));
            check({tag, " lum"}, 32'(is_luminance), 32'(ecomp == 0));
        end
        check({tag, " dc_valid"}, 32'(dc_diff_valid), 32'(dcv_exp));
        if (dcv_exp) check({tag, " dc_diff"}, 32'($signed(dc_diff)), 32'(dcd_exp));
        last_dc = int'($signed(dc_diff));
        if (input_1pix_enable === 1'b1) obs_in1++;
        if (rst_marker === 1'b1) obs_rst++;
        if (ab) begin
            for (int i = 0; i < 4; i++) pred[i] = 0;
            dcv_exp = 1'b0;
        end else begin
            if (es[0]) for (int i = 0; i < 4; i++) pred[i] = 0;
            dcv_exp = dv;
            if (dv) begin
                dcd_exp     = coef - pred[ecomp];
                pred[ecomp] = coef;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock);
        #2;
        reset = 1'b1; mcu_start = 1'b0; pix_valid = 1'b0; huff_done = 1'b0;
        dc_valid = 1'b0; abort = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check({tag, " strobes"}, 32'({busy, pix_ready, input_1pix_enable, dct_enable, dct_input_enable,
              zigzag_input_enable, Huffman_start, mcu_done, rst_marker}), 32'd0);
        check({tag, " row"}, 32'(matrix_row), 32'd0);
        check({tag, " comp"}, 32'(comp_idx), 32'd0);
        check({tag, " lum"}, 32'(is_luminance), 32'd1);
        check({tag, " dc_valid"}, 32'(dc_diff_valid), 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic idle_step(input string tag);
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 1'b0, 9'd0, 0, idle_comp, tag);
    endtask

    // One MCU; abort_row >= 0 aborts in comp 0 at that quantize row.
    task automatic run_mcu(input int gap_mode, input int hwait, input logic hearly, input logic dc_en,
                           input int dc_val, input logic dc_at_done, input int abort_row, input string tag);
        int   acc;
        int   ph;
        logic pv;
        logic fin;
        logic last;
        logic rm;
        logic ab;
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 1'b0, 9'd0, 0, idle_comp, {tag, " start"});
        for (int c = 0; c < NUM_COMP; c++) begin
            acc = 0;
            ph  = 0;
            while (acc < BLK_PIX) begin
                case (gap_mode)
                    0:       pv = 1'b1;
                    1:       pv = (ph % 2 == 0);
                    default: pv = 1'($urandom_range(0, 1));
                endcase
                step(1'($urandom_range(0, 1)), pv, 1'b0, (ph == 0) && dc_en, dc_val, 1'b0,
                     stb(1, 1, pv, 0, 0, 0, 0, 0, 0), 0, c, {tag, " load"});
                if (c == 0 && ph == 1) c0_diff = last_dc;
                if (pv) acc++;
                ph++;
            end
            for (int i = 0; i < DCT_LAT; i++)
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 1'b0,
                     stb(1, 0, 0, i == 0, 0, 0, 0, 0, 0), 0, c, {tag, " dct"});
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 1'b0,
                 stb(1, 0, 0, 0, 1, 0, 0, 0, 0), 0, c, {tag, " capt"});
            for (int r = 0; r < ROWS; r++) begin
                ab = (c == 0 && r == abort_row);
                step(ab ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, ab,
                     stb(1, 0, 0, 0, 0, 1, 0, 0, 0), r, c, {tag, " quant"});
                if (ab) begin
                    done_cnt  = 0;
                    idle_comp = 0;
                    return;
                end
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hearly, 1'b0, 0, 1'b0,
                 stb(1, 0, 0, 0, 0, 0, 1, 0, 0), 0, c, {tag, " hstart"});
            for (int w = 1; w <= hwait; w++) begin
                fin  = (w == hwait);
                last = fin && (c == NUM_COMP - 1);
                rm   = last && (done_cnt + 1 == RST_INTV);
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fin, last && dc_at_done, dc_val, 1'b0,
                     stb(1, 0, 0, 0, 0, 0, 0, last, rm), 0, c, {tag, " hwait"});
                if (last) done_cnt = rm ? 0 : done_cnt + 1;
            end
        end
        idle_comp = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rand_dc = 1'b0;
        model_reset();
        last_dc = 0;
        c0_diff = 0;
        obs_in1 = 0;
        obs_rst = 0;

        do_reset("reset");

        // signed DC difference without wrap on luminance
        step(1'b0, 1'b0, 1'b0, 1'b1, 100, 1'b0, 9'd0, 0, 0, "dc seq");
        step(1'b0, 1'b0, 1'b0, 1'b1, -20, 1'b0, 9'd0, 0, 0, "dc seq");
        check("dc seq diff 100", 32'(last_dc), 32'(100));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2047, 1'b0, 9'd0, 0, 0, "dc seq");
        check("dc seq diff -120", 32'(last_dc), 32'(-120));
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 9'd0, 0, 0, "dc seq");
        check("dc seq diff 2067", 32'(last_dc), 32'(2067));

        do_reset("reset2");
        base = obs_in1;
        run_mcu(0, 5, 1'b0, 1'b1, 37, 1'b0, -1, "b2b");
        idle_step("b2b idle");
        check("b2b pixel count", 32'(obs_in1 - base), 32'(BLK_PIX * NUM_COMP));

        base = obs_in1;
        run_mcu(1, 5, 1'b0, 1'b0, 0, 1'b0, -1, "gapped");
        idle_step("gapped idle");
        check("gapped pixel count", 32'(obs_in1 - base), 32'(BLK_PIX * NUM_COMP));

        run_mcu(0, 3, 1'b1, 1'b0, 0, 1'b0, -1, "early done");
        idle_step("early done idle");

        // restart interval of two MCUs
        do_reset("reset3");
        base = obs_rst;
        run_mcu(0, 2, 1'b0, 1'b1, 50, 1'b0, -1, "rst m1");
        check("rst m1 c0 diff", 32'(c0_diff), 32'(50));
        check("rst m1 markers", 32'(obs_rst - base), 32'd0);
        run_mcu(0, 2, 1'b0, 1'b1, 50, 1'b1, -1, "rst m2");
        check("rst m2 c0 diff", 32'(c0_diff), 32'(0));
        check("rst m2 markers", 32'(obs_rst - base), 32'd1);
        run_mcu(0, 2, 1'b0, 1'b1, 50, 1'b0, -1, "rst m3");
        check("rst m3 c0 diff", 32'(c0_diff), 32'(50));
        idle_step("rst idle");

        // reset while loading
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 9'd0, 0, idle_comp, "midrst start");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, stb(1, 1, 1, 0, 0, 0, 0, 0, 0), 0, 0, "midrst load");
        do_reset("midrst");

        // abort in quantize row 3 with live predictors
        run_mcu(0, 1, 1'b0, 1'b1, 77, 1'b0, -1, "abort pre");
        run_mcu(0, 1, 1'b0, 1'b1, 99, 1'b0, 3, "abort");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 9'd0, 0, 0, "abort idle");
        run_mcu(0, 1, 1'b0, 1'b1, 55, 1'b0, -1, "abort restart");
        check("abort restart c0 diff", 32'(c0_diff), 32'(55));
        idle_step("abort restart idle");

        // randomized MCUs with random DC traffic and one random abort
        rand_dc = 1'b1;
        for (int k = 0; k < 6; k++) begin
            run_mcu(2, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b1,
                    int'($urandom_range(0, 4095)) - 2048, 1'($urandom_range(0, 1)),
                    (k == 3) ? int'($urandom_range(0, ROWS - 1)) : -1, "random");
            idle_step("random idle");
        end
        rand_dc = 1'b0;
        idle_step("final idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
